// File: rtl/board_state_writer_pkg.sv
// Shared definitions for the tic-tac-toe board writer and its helpers.
// Cell/winner encodings, FSM states and board size.
package board_state_writer_pkg;

  localparam int BOARD_CELLS = 9;

  localparam logic [1:0] CELL_EMPTY = 2'b00;
  localparam logic [1:0] CELL_X     = 2'b01;
  localparam logic [1:0] CELL_O     = 2'b10;

  localparam logic [1:0] WIN_NONE = 2'b00;
  localparam logic [1:0] WIN_X    = 2'b01;
  localparam logic [1:0] WIN_O    = 2'b10;
  localparam logic [1:0] WIN_DRAW = 2'b11;

  typedef enum logic [1:0] {WAIT, CHECK, DONE} state_t;

  // Mark written by the player whose turn it is (0 = human/X, 1 = AI/O).
  function automatic logic [1:0] mark_of(input logic turn);
    return turn ? CELL_O : CELL_X;
  endfunction

endpackage

// File: rtl/board_state_writer_line_win_detect.sv
// Combinational three-in-a-row detector over an 18-bit packed board.
// Reports whether any row, column or diagonal is filled entirely with mark.
module line_win_detect
  import board_state_writer_pkg::*;
(
  input  logic [17:0] board,
  input  logic [1:0]  mark,
  output logic        win
);

  // Each 12-bit entry holds the three cell indices of one line.
  localparam logic [95:0] LINE_CELLS = {
    4'd2, 4'd4, 4'd6,
    4'd0, 4'd4, 4'd8,
    4'd2, 4'd5, 4'd8,
    4'd1, 4'd4, 4'd7,
    4'd0, 4'd3, 4'd6,
    4'd6, 4'd7, 4'd8,
    4'd3, 4'd4, 4'd5,
    4'd0, 4'd1, 4'd2
  };

  logic [7:0] line_hit;

  generate
    for (genvar gi = 0; gi < 8; gi++) begin : g_line
      localparam int CA = int'(LINE_CELLS[gi*12 +: 4]);
      localparam int CB = int'(LINE_CELLS[gi*12 + 4 +: 4]);
      localparam int CC = int'(LINE_CELLS[gi*12 + 8 +: 4]);
      assign line_hit[gi] = (board[2*CA +: 2] == mark) &&
                            (board[2*CB +: 2] == mark) &&
                            (board[2*CC +: 2] == mark);
    end
  endgenerate

  // An empty mark would otherwise "win" on any blank line.
  assign win = (|line_hit) && (mark != CELL_EMPTY);

endmodule

// File: rtl/board_state_writer.sv
// Tic-tac-toe board owner: accepts checked moves, alternates turns and
// latches the win/draw result until a new game is requested.
module board_state_writer
  import board_state_writer_pkg::*;
#(
  parameter bit FIRST_PLAYER = 1'b0
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       new_game,
  input  logic [3:0] move_in,
  input  logic       move_valid,
  output logic [5:0] top,
  output logic [5:0] middle,
  output logic [5:0] bottom,
  output logic       turn,
  output logic       move_ack,
  output logic       move_reject,
  output logic [3:0] move_count,
  output logic [1:0] winner,
  output logic       game_over
);

  state_t      state_reg, state_next;
  logic [17:0] board_reg, board_next;
  logic        turn_reg, turn_next;
  logic [3:0]  count_reg, count_next;
  logic [1:0]  winner_reg, winner_next;
  logic        game_over_reg, game_over_next;
  logic        ack_reg, ack_next;
  logic        reject_reg, reject_next;

  logic [1:0]  cur_mark;
  logic [8:0]  cell_sel;
  logic [8:0]  cell_free;
  logic [17:0] written_board;
  logic        accept;
  logic        line_win;

  assign cur_mark = mark_of(turn_reg);

  // Per-cell decode; an index above 8 selects no cell and is rejected.
  generate
    for (genvar gi = 0; gi < BOARD_CELLS; gi++) begin : g_cell
      assign cell_sel[gi]  = (move_in == 4'(gi));
      assign cell_free[gi] = (board_reg[2*gi +: 2] == CELL_EMPTY);
      assign written_board[2*gi +: 2] = cell_sel[gi] ? cur_mark : board_reg[2*gi +: 2];
    end
  endgenerate

  assign accept = |(cell_sel & cell_free);

  line_win_detect u_line_win_detect (
    .board (board_reg),
    .mark  (cur_mark),
    .win   (line_win)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg     <= WAIT;
      board_reg     <= '0;
      turn_reg      <= FIRST_PLAYER;
      count_reg     <= '0;
      winner_reg    <= WIN_NONE;
      game_over_reg <= 1'b0;
      ack_reg       <= 1'b0;
      reject_reg    <= 1'b0;
    end else begin
      state_reg     <= state_next;
      board_reg     <= board_next;
      turn_reg      <= turn_next;
      count_reg     <= count_next;
      winner_reg    <= winner_next;
      game_over_reg <= game_over_next;
      ack_reg       <= ack_next;
      reject_reg    <= reject_next;
    end
  end

  always_comb begin
    state_next     = state_reg;
    board_next     = board_reg;
    turn_next      = turn_reg;
    count_next     = count_reg;
    winner_next    = winner_reg;
    game_over_next = game_over_reg;
    ack_next       = 1'b0;
    reject_next    = 1'b0;

    if (new_game) begin
      state_next     = WAIT;
      board_next     = '0;
      turn_next      = FIRST_PLAYER;
      count_next     = '0;
      winner_next    = WIN_NONE;
      game_over_next = 1'b0;
    end else begin
      case (state_reg)
        WAIT: begin
          if (move_valid) begin
            if (accept) begin
              board_next = written_board;
              count_next = count_reg + 4'd1;
              ack_next   = 1'b1;
              state_next = CHECK;
            end else begin
              reject_next = 1'b1;
            end
          end
        end
        CHECK: begin
          // The board already holds the mark placed by the current player.
          if (line_win) begin
            winner_next    = cur_mark;
            game_over_next = 1'b1;
            state_next     = DONE;
          end else if (count_reg == 4'(BOARD_CELLS)) begin
            winner_next    = WIN_DRAW;
            game_over_next = 1'b1;
            state_next     = DONE;
          end else begin
            turn_next  = ~turn_reg;
            state_next = WAIT;
          end
        end
        DONE: ;
        default: state_next = WAIT;
      endcase
    end
  end

  assign top         = board_reg[5:0];
  assign middle      = board_reg[11:6];
  assign bottom      = board_reg[17:12];
  assign turn        = turn_reg;
  assign move_ack    = ack_reg;
  assign move_reject = reject_reg;
  assign move_count  = count_reg;
  assign winner      = winner_reg;
  assign game_over   = game_over_reg;

endmodule
